// File: rtl/flush_redirect_ctrl_pkg.sv
// Shared definitions for the flush/redirect sequencer: state and event encodings,
// the interrupt exception code, and the event priority selector.
package flush_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        FRC_IDLE  = 2'd0,
        FRC_FLUSH = 2'd1,
        FRC_REDIR = 2'd2
    } frc_state_e;

    typedef enum logic [1:0] {
        FRC_EV_NONE = 2'd0,
        FRC_EV_EX   = 2'd1,
        FRC_EV_ERTN = 2'd2,
        FRC_EV_INT  = 2'd3
    } frc_event_e;

    localparam logic [5:0] ECODE_INT = 6'h0;

    // Exception beats ertn beats interrupt; interrupts only at a commit boundary.
    function automatic frc_event_e frc_select_event(
        input logic ex,
        input logic ertn,
        input logic int_at_commit
    );
        frc_event_e ev;
        if (ex)
            ev = FRC_EV_EX;
        else if (ertn)
            ev = FRC_EV_ERTN;
        else if (int_at_commit)
            ev = FRC_EV_INT;
        else
            ev = FRC_EV_NONE;
        return ev;
    endfunction

endpackage

// File: rtl/flush_redirect_ctrl.sv
// Pipeline flush and PC-redirect sequencer: one WB event -> flush window -> redirect handshake.
// Owns the int_take pulse towards the CSR file.
module flush_redirect_ctrl
    import flush_redirect_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned PC_W         = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            wb_ex,
    input  logic            wb_ertn,
    input  logic            wb_commit,
    input  logic            int_pending,
    input  logic [PC_W-1:0] csr_eentry,
    input  logic [PC_W-1:0] csr_era,
    output logic            flush_out,
    output logic            int_take,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            busy
);

    localparam int unsigned CNT_W = $clog2(FLUSH_CYCLES + 1);

    frc_state_e       state_q;
    frc_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    frc_event_e       event_sel;
    logic             event_fire;
    logic [PC_W-1:0]  target_pc;

    // Events are qualified by resetn so nothing combinational leaks out while in reset.
    always_comb begin
        event_sel = FRC_EV_NONE;
        if (resetn && state_q == FRC_IDLE)
            event_sel = frc_select_event(wb_ex, wb_ertn, int_pending & wb_commit);
    end

    assign event_fire = (event_sel != FRC_EV_NONE);

    always_comb begin
        target_pc = (event_sel == FRC_EV_ERTN) ? csr_era : csr_eentry;
        target_pc[1:0] = 2'b00;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_q <= FRC_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FRC_IDLE:  if (event_fire)                     state_d = FRC_FLUSH;
            FRC_FLUSH: if (cnt_q == '0)                    state_d = FRC_REDIR;
            FRC_REDIR: if (redirect_ready)                 state_d = FRC_IDLE;
            default:                                       state_d = FRC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q       <= '0;
            redirect_pc <= '0;
        end else begin
            if (event_fire) begin
                cnt_q       <= CNT_W'(FLUSH_CYCLES - 1);
                redirect_pc <= target_pc;
            end else if (state_q == FRC_FLUSH && cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        flush_out      = 1'b0;
        int_take       = 1'b0;
        redirect_valid = 1'b0;
        busy           = 1'b0;
        case (state_q)
            FRC_IDLE: begin
                flush_out = event_fire;
                int_take  = (event_sel == FRC_EV_INT);
            end
            FRC_FLUSH: begin
                flush_out = 1'b1;
                busy      = 1'b1;
            end
            FRC_REDIR: begin
                redirect_valid = 1'b1;
                busy           = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// Scoreboard bench for flush_redirect_ctrl: expected redirect PCs are queued at each event
// and popped by an independent monitor on every redirect handshake.
module tb_flush_redirect_ctrl;

    localparam int unsigned FC   = 1;
    localparam int unsigned PC_W = 32;

    logic            clk = 1'b0;
    logic            resetn;
    logic            wb_ex, wb_ertn, wb_commit, int_pending;
    logic [PC_W-1:0] csr_eentry, csr_era;
    logic            flush_out, int_take, redirect_valid, redirect_ready, busy;
    logic [PC_W-1:0] redirect_pc;

    int unsigned     compared   = 0;
    int unsigned     mismatched = 0;
    int unsigned     hs_count   = 0;
    logic [PC_W-1:0] exp_q[$];

    always #5 clk = ~clk;

    flush_redirect_ctrl #(.FLUSH_CYCLES(FC), .PC_W(PC_W)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .wb_ex          (wb_ex),
        .wb_ertn        (wb_ertn),
        .wb_commit      (wb_commit),
        .int_pending    (int_pending),
        .csr_eentry     (csr_eentry),
        .csr_era        (csr_era),
        .flush_out      (flush_out),
        .int_take       (int_take),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .busy           (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: samples between the driving negedge and the next posedge.
    always begin
        @(negedge clk);
        #2;
        if (resetn === 1'b1) begin
            if (redirect_valid === 1'b1 && redirect_ready === 1'b1) begin
                hs_count++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_redirect: got pc 0x%08h expected no handshake", redirect_pc);
                end else begin
                    check("redirect_pc", redirect_pc, exp_q.pop_front());
                end
            end
            if (int_take === 1'b1)
                check("int_take_while_busy", {31'd0, busy}, 32'd0);
        end
    end

    task automatic clear_inputs();
        wb_ex = 1'b0; wb_ertn = 1'b0; wb_commit = 1'b0; int_pending = 1'b0;
        csr_eentry = 32'hDEAD_BEEF; csr_era = 32'hDEAD_BEEF;
    endtask

    // Issue one event, check the event cycle and flush window; returns positioned inside REDIR.
    task automatic fire(input string tag, input logic ex, input logic ertn, input logic commit,
                        input logic intp, input logic [31:0] ee, input logic [31:0] er,
                        input logic exp_int, input logic [31:0] exp_pc);
        int unsigned n;
        @(negedge clk);
        wb_ex = ex; wb_ertn = ertn; wb_commit = commit; int_pending = intp;
        csr_eentry = ee; csr_era = er;
        #1;
        check({tag, "_evt_flush"}, {31'd0, flush_out}, 32'd1);
        check({tag, "_int_take"}, {31'd0, int_take}, {31'd0, exp_int});
        exp_q.push_back(exp_pc);
        @(negedge clk);
        clear_inputs();
        #1;
        n = 1;
        while (flush_out === 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
            #1;
        end
        check({tag, "_flush_len"}, n, 1 + FC);
        check({tag, "_valid_after_flush"}, {31'd0, redirect_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned hs_before;
        resetn = 1'b0;
        redirect_ready = 1'b1;
        clear_inputs();
        repeat (3) @(negedge clk);
        #1;
        check("rst_flush", {31'd0, flush_out}, 32'd0);
        check("rst_valid", {31'd0, redirect_valid}, 32'd0);
        check("rst_pc", redirect_pc, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Exception, ready=1: 2 flush cycles then a single-cycle redirect.
        fire("ex", 1, 0, 0, 0, 32'h1C00_8000, 32'h0, 0, 32'h1C00_8000);
        @(negedge clk); #1;
        check("ex_valid_drop", {31'd0, redirect_valid}, 32'd0);
        check("ex_idle", {31'd0, busy}, 32'd0);

        // ertn with low bits set, stalled by IF for 3 cycles.
        redirect_ready = 1'b0;
        fire("ertn", 0, 1, 0, 0, 32'h1C00_8000, 32'h1C00_0123, 0, 32'h1C00_0120);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", {31'd0, redirect_valid}, 32'd1);
            check("stall_pc", redirect_pc, 32'h1C00_0120);
            @(negedge clk); #1;
        end
        redirect_ready = 1'b1;
        @(negedge clk); #1;
        check("stall_valid_drop", {31'd0, redirect_valid}, 32'd0);

        // Exception and ertn together: exception target wins.
        fire("ex_ertn", 1, 1, 0, 0, 32'h1C00_4444, 32'h1C00_7770, 0, 32'h1C00_4444);
        @(negedge clk);

        // Interrupt at commit boundary.
        fire("int", 0, 0, 1, 1, 32'h1C00_9003, 32'h1C00_1110, 1, 32'h1C00_9000);
        @(negedge clk);

        // Second exception inside the flush window must be ignored.
        hs_before = hs_count;
        @(negedge clk);
        wb_ex = 1'b1; csr_eentry = 32'h1C00_A000;
        exp_q.push_back(32'h1C00_A000);
        @(negedge clk);
        csr_eentry = 32'h0; wb_commit = 1'b1; int_pending = 1'b1;
        #1;
        check("busy_evt_int_take", {31'd0, int_take}, 32'd0);
        check("busy_evt_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        clear_inputs();
        repeat (6) @(negedge clk);
        #1;
        check("busy_evt_handshakes", hs_count - hs_before, 32'd1);
        check("busy_evt_idle", {31'd0, busy}, 32'd0);

        // Interrupt pending without a commit: no action.
        int_pending = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check("noint_busy", {31'd0, busy}, 32'd0);
            check("noint_take", {31'd0, int_take}, 32'd0);
            check("noint_flush", {31'd0, flush_out}, 32'd0);
        end
        int_pending = 1'b0;

        // Reset asserted mid-REDIR.
        redirect_ready = 1'b0;
        fire("rstmid", 1, 0, 0, 0, 32'h1C00_4000, 32'h0, 0, 32'h1C00_4000);
        resetn = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("rstmid_flush", {31'd0, flush_out}, 32'd0);
        check("rstmid_int_take", {31'd0, int_take}, 32'd0);
        check("rstmid_valid", {31'd0, redirect_valid}, 32'd0);
        check("rstmid_pc", redirect_pc, 32'd0);
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        redirect_ready = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk); #1;
        check("rstmid_after_busy", {31'd0, busy}, 32'd0);
        check("rstmid_after_valid", {31'd0, redirect_valid}, 32'd0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
